// File: rtl/sysid_uptime.sv
// System ID Avalon-MM slave with scratch register, 64-bit uptime counter,
// coherent high-word snapshot and sticky overflow flag. Read latency is fixed at 1.
module sysid_uptime #(
  parameter logic [31:0] ID_VALUE      = 32'd0,
  parameter logic [31:0] TIMESTAMP     = 32'd1361488137,
  parameter logic [31:0] VERSION       = 32'h0001_0000,
  parameter int unsigned TICK_DIV      = 50,
  parameter logic [31:0] SCRATCH_RESET = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    REG_ID        = 3'd0,
    REG_TIMESTAMP = 3'd1,
    REG_VERSION   = 3'd2,
    REG_SCRATCH   = 3'd3,
    REG_UPTIME_LO = 3'd4,
    REG_SHADOW_HI = 3'd5,
    REG_STATUS    = 3'd6,
    REG_RESERVED  = 3'd7
  } reg_addr_t;

  reg_addr_t     reg_addr;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [63:0]   uptime;
  logic [31:0]   shadow_hi;
  logic [31:0]   scratch;
  logic [31:0]   scratch_next;
  logic          ovf;
  logic          ovf_set;
  logic          ovf_clr;
  logic          rd_en;
  logic          snap_en;
  logic [31:0]   rd_mux;

  always_comb begin
    reg_addr = reg_addr_t'(address);
    // Write wins a read/write collision, so the read is suppressed entirely.
    rd_en    = read & ~write;
    snap_en  = rd_en && (reg_addr == REG_UPTIME_LO);
    tick     = (prescaler == PRE_LAST);
    ovf_set  = tick && (uptime == '1);
    ovf_clr  = write && (reg_addr == REG_STATUS) && byteenable[0] && writedata[0];
  end

  always_comb begin
    scratch_next = scratch;
    if (write && (reg_addr == REG_SCRATCH)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteenable[i]) scratch_next[8*i +: 8] = writedata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_ID:        rd_mux = ID_VALUE;
      REG_TIMESTAMP: rd_mux = TIMESTAMP;
      REG_VERSION:   rd_mux = VERSION;
      REG_SCRATCH:   rd_mux = scratch;
      REG_UPTIME_LO: rd_mux = uptime[31:0];
      REG_SHADOW_HI: rd_mux = shadow_hi;
      REG_STATUS:    rd_mux = {31'd0, ovf};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      uptime    <= '0;
      ovf       <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) uptime <= uptime + 64'd1;
      // A coincident wrap beats a W1C clear.
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch       <= SCRATCH_RESET;
      shadow_hi     <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      scratch       <= scratch_next;
      readdatavalid <= rd_en;
      if (rd_en) readdata <= rd_mux;
      // Snapshot uses the pre-increment value, matching the low word returned.
      if (snap_en) shadow_hi <= uptime[63:32];
    end
  end

endmodule

// File: tb/tb_sysid_uptime.sv
// Directed bench for sysid_uptime: vector table for the register map, plus
// hand sequences for uptime timing, snapshot coherence, overflow and async reset.
module tb_sysid_uptime;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata4, readdata1;
  logic        rdv4, rdv1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sysid_uptime #(.TICK_DIV(4)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata4), .readdatavalid(rdv4)
  );

  sysid_uptime #(.TICK_DIV(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata1), .readdatavalid(rdv1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = wdata;
    byteenable = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0,          4'h0, 1'b1, 32'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 32'h0,          4'h0, 1'b1, 32'd1361488137};
    vecs[2]  = '{1'b1, 1'b0, 3'd2, 32'h0,          4'h0, 1'b1, 32'h0001_0000};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF,  4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'd3, 32'h0000_0011,  4'h1, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'd3, 32'h0,          4'h0, 1'b1, 32'hDEAD_BE11};
    vecs[6]  = '{1'b0, 1'b1, 3'd1, 32'h1234_5678,  4'hF, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 3'd1, 32'h0,          4'h0, 1'b1, 32'd1361488137};
    vecs[8]  = '{1'b1, 1'b0, 3'd5, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'd3, 32'hCAFE_F00D,  4'hC, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 32'h0,          4'h0, 1'b1, 32'hCAFE_BE11};
    vecs[11] = '{1'b0, 1'b1, 3'd3, 32'hFFFF_FFFF,  4'h0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'd3, 32'h0,          4'h0, 1'b1, 32'hCAFE_BE11};
    vecs[13] = '{1'b1, 1'b0, 3'd7, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 3'd7, 32'hFFFF_FFFF,  4'hF, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 3'd6, 32'h0,          4'h0, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 32'h0,          4'h0, 1'b0, 32'h0};

    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clock);
    check("reset_readdata", readdata4, 32'd0);
    check("reset_valid", {31'd0, rdv4}, 32'd0);

    // Release at a negedge; after posedge n the TICK_DIV=4 uptime is n/4.
    reset_n = 1'b1;
    repeat (40) @(posedge clock);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
    @(negedge clock);
    check("uptime_div4_valid", {31'd0, rdv4}, 32'd1);
    check("uptime_div4", readdata4, 32'd10);
    check("uptime_div1", readdata1, 32'd40);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      @(negedge clock);
      check($sformatf("vec%0d_valid", i), {31'd0, rdv4}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), readdata4, vecs[i].exp_data);
    end

    // Snapshot coherence: every cycle is a tick on dut1.
    dut1.uptime = 64'h0000_0000_FFFF_FFFF;
    drive(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
    @(negedge clock);
    check("snap_lo", readdata1, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
    @(negedge clock);
    check("snap_hi_valid", {31'd0, rdv1}, 32'd1);
    check("snap_hi", readdata1, 32'h0);
    check("live_hi", dut1.uptime[63:32], 32'd1);

    // Overflow and W1C behaviour.
    idle();
    dut1.uptime = '1;
    @(negedge clock);
    check("wrap_uptime_lo", dut1.uptime[31:0], 32'd0);
    drive(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
    @(negedge clock);
    check("ovf_set", readdata1, 32'd1);
    drive(1'b0, 1'b1, 3'd6, 32'd0, 4'hF);
    @(negedge clock);
    drive(1'b0, 1'b1, 3'd6, 32'd1, 4'hE);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
    @(negedge clock);
    check("ovf_no_clear", readdata1, 32'd1);
    drive(1'b0, 1'b1, 3'd6, 32'd1, 4'h1);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
    @(negedge clock);
    check("ovf_cleared", readdata1, 32'd0);
    dut1.uptime = '1;
    drive(1'b0, 1'b1, 3'd6, 32'd1, 4'h1);
    @(negedge clock);
    drive(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
    @(negedge clock);
    check("ovf_set_wins", readdata1, 32'd1);

    // Async reset one cycle after a read, between clock edges.
    drive(1'b1, 1'b0, 3'd3, 32'd0, 4'd0);
    @(posedge clock);
    #2;
    idle();
    check("pre_reset_valid", {31'd0, rdv4}, 32'd1);
    check("pre_reset_data", readdata4, 32'hCAFE_BE11);
    reset_n = 1'b0;
    #1;
    check("async_valid", {31'd0, rdv4}, 32'd0);
    check("async_data", readdata4, 32'd0);
    check("async_data1", readdata1, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 3'd3, 32'd0, 4'd0);
    @(negedge clock);
    check("scratch_after_reset", readdata4, 32'd0);
    drive(1'b1, 1'b0, 3'd4, 32'd0, 4'd0);
    @(negedge clock);
    check("uptime4_after_reset", readdata4, 32'd0);
    check("uptime1_after_reset", readdata1, 32'd1);
    idle();
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sysid_uptime.md
Name: sysid_uptime

Overview:
Parametrised successor to the fixed two-word system ID slave. It is an Avalon-MM slave on the Nios II data master. It returns system ID, build timestamp and version words, and adds the following:
- a byte-writable scratch register
- a 64-bit uptime counter with a coherent snapshot read
- a sticky overflow status bit
Readdata is registered (fixed read latency 1) so the block closes timing on the shared interconnect.

Parameters:
ID_VALUE, 0, value returned at word 0 (system ID)
TIMESTAMP, 1361488137, value returned at word 1 (build timestamp, seconds)
VERSION, 32'h0001_0000, value returned at word 2 (major[31:16], minor[15:0])
TICK_DIV, 50, clock cycles per uptime tick (>=1; 50 gives 1 us at 50 MHz)
SCRATCH_RESET, 0, reset value of scratch register

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  word address
read  input  1  read strobe, single cycle per transfer
write  input  1  write strobe, single cycle per transfer
writedata  input  32  write data
byteenable  input  4  byte lanes for write
readdata  output  32  read data, valid when readdatavalid=1
readdatavalid  output  1  one-cycle pulse, cycle after an accepted read

Behaviour:
- Clock and reset: one clock `clock`. Reset is asynchronous, active-low, on `reset_n`. All flops clear on the reset_n falling edge, independent of clock.
- Reset values:
  - readdata=0, readdatavalid=0
  - scratch=SCRATCH_RESET
  - prescaler=0, uptime=0, shadow_hi=0, ovf=0
- Waitrequest: no waitrequest; every strobe is accepted in its cycle.
- Read latency: read at cycle N gives readdatavalid=1 and readdata at N+1. Back-to-back reads give back-to-back valid pulses.
- Read/write collision: read and write asserted together performs the write only. No readdatavalid in that case.
- Register map (word addresses):
  - 0 ID_VALUE (RO)
  - 1 TIMESTAMP (RO)
  - 2 VERSION (RO)
  - 3 scratch (RW, per-byte via byteenable; byteenable=0 leaves it unchanged)
  - 4 uptime[31:0] (RO). A read also copies uptime[63:32] into shadow_hi in the same cycle. Low and high words come from the same counter value.
  - 5 shadow_hi (RO). Returns the last snapshot; never the live high word.
  - 6 status (bit0=ovf sticky, bits31:1 read 0). Writing 1 to bit0 with byteenable[0]=1 clears ovf; writing 0 has no effect.
  - 7 reserved: reads 0, writes ignored.
- Writes to RO addresses are ignored. They have no side effect on counters or shadow.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps to 0.
  - the wrap cycle asserts tick.
  - TICK_DIV=1 asserts tick every cycle.
- Uptime:
  - 64-bit, increments by 1 on each tick.
  - wraps from all-ones to 0 and sets ovf on that same cycle.
- ovf conflicts: if the ovf set and a W1C clear coincide, set wins (ovf=1).
- Snapshot read value: a read of address 4 in the cycle uptime increments returns the pre-increment low word. shadow_hi takes the matching pre-increment high word.
- Counters never stall: reads and writes do not stop the prescaler or uptime.
- Reset mid-transaction: a pending readdatavalid is dropped. Counters restart from 0.

Test Plan:
- Reset, then read addr 0,1,2 back-to-back (defaults) -> readdatavalid high on 3 consecutive cycles. Data 0, 1361488137, 0x00010000, each one cycle after its read.
- Write scratch 0xDEADBEEF (be=4'hF), then write 0x00000011 with be=4'b0001, then read addr 3 -> 0xDEADBE11. Write to addr 1 then read addr 1 -> still 1361488137.
- TICK_DIV=4: release reset, wait 40 cycles, read addr 4 -> 10 (±1 per documented alignment). Read addr 5 -> 0. Simultaneous read+write at addr 3 -> no readdatavalid, scratch updated.
- Snapshot coherence: force uptime=0x0000_0000_FFFF_FFFF (via hierarchical preload), read addr 4 on a tick cycle -> 0xFFFFFFFF. Next read addr 5 -> 0x00000000 (not 1), even though live high is now 1.
- Overflow: preload uptime all-ones, TICK_DIV=1 -> next cycle uptime=0 and status read =1. Write 1 to addr 6 -> status 0. Write 1 on the overflow cycle -> status remains 1.
- Assert reset_n low asynchronously between clock edges, one cycle after a read -> readdatavalid and readdata drop to 0 immediately. Scratch returns to SCRATCH_RESET, uptime=0.
